// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants, receiver state encoding and pixel type.
// Used by the VGA timing generator and by vga_rx_monitor.
package vga_timing_pkg;

  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_TOTAL   = 800;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_TOTAL   = 525;

  localparam logic VGA_SYNC_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
  } rgb332_t;

  // CRC-16-CCITT (poly 0x1021), one byte, MSB first
  function automatic logic [15:0] crc16_ccitt_byte(
    input logic [15:0] crc,
    input logic [7:0]  data
  );
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop synchronizer for a sync input plus a leading-edge detector
// that only looks at the line on pixel-strobe cycles.
module vga_sync_edge #(
  parameter logic ACTIVE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pix_en_i,
  input  logic sync_i,
  output logic edge_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= ~ACTIVE;
      s2_q   <= ~ACTIVE;
      prev_q <= ~ACTIVE;
    end else begin
      s1_q <= sync_i;
      s2_q <= s1_q;
      if (pix_en_i) begin
        prev_q <= s2_q;
      end
    end
  end

  assign edge_o = pix_en_i
                & (s2_q == ACTIVE)
                & (prev_q != ACTIVE);

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive-side monitor: recovers pixel coordinates and checks timing.
// Define VGA_RX_CHECKSUM_EN to add the per-frame CRC-16 outputs.
module vga_rx_monitor
  import vga_timing_pkg::*;
#(
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BACK      = VGA_H_BACK,
  parameter int   H_VISIBLE   = VGA_H_VISIBLE,
  parameter int   H_TOTAL     = VGA_H_TOTAL,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BACK      = VGA_V_BACK,
  parameter int   V_VISIBLE   = VGA_V_VISIBLE,
  parameter int   V_TOTAL     = VGA_V_TOTAL,
  parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [2:0] red_in,
  input  logic [2:0] green_in,
  input  logic [1:0] blue_in,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [7:0] pix_data,
  output logic       frame_start,
  output logic       locked,
  output logic       lock_lost,
  output logic [9:0] meas_h_total,
  output logic [9:0] meas_v_total
`ifdef VGA_RX_CHECKSUM_EN
  ,
  output logic [15:0] frame_crc,
  output logic        crc_valid
`endif
);

  localparam logic [9:0] H_ACT0 = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT1 = 10'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [9:0] V_ACT0 = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT1 = 10'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [9:0] H_TOT  = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT  = 10'(V_TOTAL);
  localparam logic [11:0] WD_LAST = 12'(2 * H_TOTAL - 1);

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  logic h_edge;
  logic v_edge;

  vga_sync_edge #(
    .ACTIVE (SYNC_ACTIVE)
  ) u_hsync (
    .clk_i    (clock),
    .rst_ni   (rst_n),
    .pix_en_i (pix_en),
    .sync_i   (hsync_in),
    .edge_o   (h_edge)
  );

  vga_sync_edge #(
    .ACTIVE (SYNC_ACTIVE)
  ) u_vsync (
    .clk_i    (clock),
    .rst_ni   (rst_n),
    .pix_en_i (pix_en),
    .sync_i   (vsync_in),
    .edge_o   (v_edge)
  );

  // Pixel bus delayed to line up with the synchronized syncs
  rgb332_t rgb_in;
  rgb332_t rgb1_q;
  rgb332_t rgb2_q;

  assign rgb_in = {red_in, green_in, blue_in};

  rx_state_e   state_q, state_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [9:0]  meas_h_q, meas_h_d;
  logic [9:0]  meas_v_q, meas_v_d;
  logic [11:0] wd_q, wd_d;
  logic        valid_q, valid_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  rgb332_t     data_q, data_d;
  logic        fs_q, fs_d;
  logic        locked_q, locked_d;
  logic        lost_q, lost_d;

  logic [9:0] h_line;
  logic [9:0] v_next;
  logic       in_win;

  assign h_line = sat_inc(h_cnt_q);
  assign v_next = sat_inc(v_cnt_q);

  always_comb begin
    state_d  = state_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    meas_h_d = meas_h_q;
    meas_v_d = meas_v_q;
    wd_d     = wd_q;
    valid_d  = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    data_d   = data_q;
    fs_d     = 1'b0;
    lost_d   = 1'b0;
    in_win   = 1'b0;

    if (pix_en) begin
      h_cnt_d = h_line;
      wd_d    = wd_q + 12'd1;

      // Line update comes before the frame update on a shared tick
      if (h_edge) begin
        meas_h_d = h_line;
        h_cnt_d  = '0;
        v_cnt_d  = v_next;
        wd_d     = '0;
      end

      if (v_edge) begin
        meas_v_d = v_next;
        v_cnt_d  = '0;
        fs_d     = 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (v_edge) begin
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (v_edge && meas_h_d == H_TOT
              && v_next == V_TOT) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if ((h_edge && h_line != H_TOT)
              || (v_edge && v_next != V_TOT)) begin
            state_d = MEASURE;
            lost_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (!h_edge && wd_q == WD_LAST) begin
        state_d = IDLE;
        wd_d    = '0;
        lost_d  = (state_q == LOCKED);
      end

      in_win = (h_cnt_d >= H_ACT0) && (h_cnt_d < H_ACT1)
            && (v_cnt_d >= V_ACT0) && (v_cnt_d < V_ACT1);

      if (state_d == LOCKED && in_win) begin
        valid_d = 1'b1;
        x_d     = h_cnt_d - H_ACT0;
        y_d     = v_cnt_d - V_ACT0;
        data_d  = rgb2_q;
      end
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rgb1_q   <= '0;
      rgb2_q   <= '0;
      state_q  <= IDLE;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      meas_h_q <= '0;
      meas_v_q <= '0;
      wd_q     <= '0;
      valid_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      data_q   <= '0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      rgb1_q   <= rgb_in;
      rgb2_q   <= rgb1_q;
      state_q  <= state_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      meas_h_q <= meas_h_d;
      meas_v_q <= meas_v_d;
      wd_q     <= wd_d;
      valid_q  <= valid_d;
      x_q      <= x_d;
      y_q      <= y_d;
      data_q   <= data_d;
      fs_q     <= fs_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  assign pix_valid    = valid_q;
  assign pix_x        = x_q;
  assign pix_y        = y_q;
  assign pix_data     = data_q;
  assign frame_start  = fs_q;
  assign locked       = locked_q;
  assign lock_lost    = lost_q;
  assign meas_h_total = meas_h_q;
  assign meas_v_total = meas_v_q;

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] crc_q, crc_d;
  logic [15:0] fcrc_q, fcrc_d;
  logic        cv_q, cv_d;

  always_comb begin
    crc_d  = crc_q;
    fcrc_d = fcrc_q;
    cv_d   = 1'b0;
    if (valid_d) begin
      crc_d = crc16_ccitt_byte(crc_q, data_d);
    end
    // Only a frame accumulated entirely under lock is reported
    if (pix_en && v_edge) begin
      if (state_q == LOCKED) begin
        fcrc_d = crc_q;
        cv_d   = 1'b1;
      end
      crc_d = 16'hFFFF;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      crc_q  <= 16'hFFFF;
      fcrc_q <= '0;
      cv_q   <= 1'b0;
    end else begin
      crc_q  <= crc_d;
      fcrc_q <= fcrc_d;
      cv_q   <= cv_d;
    end
  end

  assign frame_crc = fcrc_q;
  assign crc_valid = cv_q;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a reduced 16x9 timing mode.
// Optional CRC checks compile in when VGA_RX_CHECKSUM_EN is defined.
module tb_vga_rx_monitor;

  localparam int HS = 4;
  localparam int HB = 2;
  localparam int HV = 8;
  localparam int HT = 16;
  localparam int VS = 1;
  localparam int VB = 2;
  localparam int VV = 4;
  localparam int VT = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [2:0] red_in = '0;
  logic [2:0] green_in = '0;
  logic [1:0] blue_in = '0;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [7:0] pix_data;
  logic       frame_start;
  logic       locked;
  logic       lock_lost;
  logic [9:0] meas_h_total;
  logic [9:0] meas_v_total;
`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] frame_crc;
  logic        crc_valid;
`endif

  vga_rx_monitor #(
    .H_SYNC      (HS),
    .H_BACK      (HB),
    .H_VISIBLE   (HV),
    .H_TOTAL     (HT),
    .V_SYNC      (VS),
    .V_BACK      (VB),
    .V_VISIBLE   (VV),
    .V_TOTAL     (VT),
    .SYNC_ACTIVE (1'b0)
  ) dut (
    .clock        (clk),
    .rst_n        (rst_n),
    .pix_en       (pix_en),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .red_in       (red_in),
    .green_in     (green_in),
    .blue_in      (blue_in),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_data     (pix_data),
    .frame_start  (frame_start),
    .locked       (locked),
    .lock_lost    (lock_lost),
    .meas_h_total (meas_h_total),
    .meas_v_total (meas_v_total)
`ifdef VGA_RX_CHECKSUM_EN
    ,
    .frame_crc    (frame_crc),
    .crc_valid    (crc_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int fs_cnt = 0;
  int lost_cnt = 0;
  int vcnt = 0;
  int rise_fs = 0;
  int cyc_pin = 0;
  int cyc_out = 0;
  int crc_cnt = 0;
  logic [9:0]  lost_meas = '0;
  logic [9:0]  last_x = '0;
  logic [9:0]  last_y = '0;
  logic [9:0]  fx = '0;
  logic [9:0]  fy = '0;
  logic [7:0]  fd = '0;
  logic [15:0] crc_cap = '0;
  logic        first_seen = 1'b0;
  logic        lk_prev = 1'b0;

  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (lock_lost) begin
      lost_cnt++;
      lost_meas = meas_h_total;
    end
    if (pix_valid) begin
      vcnt++;
      last_x = pix_x;
      last_y = pix_y;
      if (!first_seen) begin
        first_seen = 1'b1;
        fx = pix_x;
        fy = pix_y;
        fd = pix_data;
        cyc_out = cyc;
      end
    end
    if (locked && !lk_prev) rise_fs = frame_start ? fs_cnt : -1;
    lk_prev = locked;
`ifdef VGA_RX_CHECKSUM_EN
    if (crc_valid) begin
      crc_cnt++;
      crc_cap = frame_crc;
    end
`endif
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Generator position and line-length override
  int   hc = 0;
  int   ln = 0;
  int   hlen = HT;
  logic zero_data = 1'b0;

  task automatic drive(input logic hs, input logic vs,
                       input logic [7:0] d);
    hsync_in = hs;
    vsync_in = vs;
    {red_in, green_in, blue_in} = d;
    pix_en = 1'b1;
    if (d == 8'hE3) cyc_pin = cyc;
    @(posedge clk);
    #1 pix_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    logic [7:0] d;
    logic vis;
    vis = (hc >= HS + HB) && (hc < HS + HB + HV)
       && (ln >= VS + VB) && (ln < VS + VB + VV);
    d = 8'h00;
    if (vis && !zero_data) begin
      d = (hc == HS + HB && ln == VS + VB) ? 8'hE3 : 8'h5A;
    end
    drive((hc < HS) ? 1'b0 : 1'b1, (ln < VS) ? 1'b0 : 1'b1, d);
    hc++;
    if (hc >= hlen) begin
      hc = 0;
      hlen = HT;
      ln = (ln + 1 == VT) ? 0 : ln + 1;
    end
  endtask

  task automatic frame(input int short_ln);
    do begin
      if (hc == 0 && ln == short_ln) hlen = HT - 1;
      step();
    end while (hc != 0 || ln != 0);
  endtask

  task automatic begin_frame();
    vcnt = 0;
    first_seen = 1'b0;
  endtask

  function automatic logic [15:0] crc_ref(input int n,
                                          input logic [7:0] b);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[15] ^ b[i];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  int fs_before;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", pix_valid, 0);
    check("rst_x", pix_x, 0);
    check("rst_y", pix_y, 0);
    check("rst_data", pix_data, 0);
    check("rst_fs", frame_start, 0);
    check("rst_locked", locked, 0);
    check("rst_lost", lock_lost, 0);
    check("rst_mh", meas_h_total, 0);
    check("rst_mv", meas_v_total, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fs_cnt = 0;
    lost_cnt = 0;

    begin_frame();
    frame(-1);
    check("f1_locked", locked, 0);
    check("f1_fs", fs_cnt, 1);
    check("f1_valid", vcnt, 0);

    zero_data = 1'b1;
    begin_frame();
    frame(-1);
    zero_data = 1'b0;
    check("f2_rise_at_fs", rise_fs, 2);
    check("f2_locked", locked, 1);
    check("f2_valid", vcnt, HV * VV);
    check("f2_mh", meas_h_total, HT);
    check("f2_mv", meas_v_total, VT);
    check("f2_last_x", last_x, HV - 1);
    check("f2_last_y", last_y, VV - 1);
    check("f2_x_hold", pix_x, HV - 1);

    begin_frame();
    frame(-1);
    check("f3_valid", vcnt, HV * VV);
    check("f3_first_x", fx, 0);
    check("f3_first_y", fy, 0);
    check("f3_first_d", fd, 8'hE3);
    check("f3_latency", cyc_out - cyc_pin, 3);
    check("f3_fs", fs_cnt, 3);
`ifdef VGA_RX_CHECKSUM_EN
    check("crc_pulses", crc_cnt, 1);
    check("crc_zero", crc_cap, crc_ref(HV * VV, 8'h00));
`endif

    begin_frame();
    frame(5);
    check("short_lost", lost_cnt, 1);
    check("short_meas", lost_meas, HT - 1);
    check("short_locked", locked, 0);
    check("short_valid", vcnt, HV * 3);

    begin_frame();
    frame(-1);
    begin_frame();
    frame(-1);
    check("relock_locked", locked, 1);
    check("relock_valid", vcnt, HV * VV);
    check("relock_lost", lost_cnt, 1);

    fs_before = fs_cnt;
    begin_frame();
    repeat (2 * HT + 8) drive(1'b1, 1'b1, 8'h00);
    check("wd_locked", locked, 0);
    check("wd_lost", lost_cnt, 2);
    check("wd_no_fs", fs_cnt, fs_before);
    check("wd_valid", vcnt, 0);

    begin_frame();
    frame(-1);
    check("wdA_fs", fs_cnt, fs_before + 1);
    check("wdA_locked", locked, 0);
    check("wdA_valid", vcnt, 0);
    begin_frame();
    frame(-1);
    check("wdB_locked", locked, 1);
    check("wdB_valid", vcnt, HV * VV);

    while (!(ln == 4 && hc == 12)) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_locked", locked, 0);
    check("mid_rst_mh", meas_h_total, 0);
    check("mid_rst_mv", meas_v_total, 0);
    check("mid_rst_x", pix_x, 0);
    check("mid_rst_data", pix_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    begin_frame();
    frame(-1);
    check("rstC_valid", vcnt, 0);
    check("rstC_locked", locked, 0);
    begin_frame();
    frame(-1);
    check("rstD_valid", vcnt, 0);
    check("rstD_locked", locked, 0);
    begin_frame();
    frame(-1);
    check("rstE_locked", locked, 1);
    check("rstE_valid", vcnt, HV * VV);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
